// File: rtl/vga_command_sequencer.sv
// Drawing-command engine: sequences framebuffer/palette write strobes one per clk
// and flips the front-buffer select on the first frame pulse after a swap request.
module vga_command_sequencer #(
  parameter int unsigned FB_WIDTH          = 160,
  parameter int unsigned FB_HEIGHT         = 120,
  parameter int unsigned FB_ADDRESS_WIDTH  = 15,
  parameter int unsigned COLOR_INDEX_WIDTH = 8,
  parameter int unsigned COLOR_WIDTH       = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [7:0]                   cmd_x,
  input  logic [6:0]                   cmd_y,
  input  logic [7:0]                   cmd_w,
  input  logic [6:0]                   cmd_h,
  input  logic [COLOR_INDEX_WIDTH-1:0] cmd_index,
  input  logic [COLOR_WIDTH-1:0]       cmd_rgb,
  input  logic                         frame_sys,
  output logic                         fb_write,
  output logic [FB_ADDRESS_WIDTH-1:0]  fb_address,
  output logic [COLOR_INDEX_WIDTH-1:0] fb_data,
  output logic                         pl_write,
  output logic [COLOR_INDEX_WIDTH-1:0] pl_address,
  output logic [COLOR_WIDTH-1:0]       pl_data,
  output logic                         current_frame,
  output logic                         busy
);

  localparam int unsigned AW = FB_ADDRESS_WIDTH;
  localparam logic [1:0] OP_SWAP = 2'd0;
  localparam logic [1:0] OP_PLOT = 2'd1;
  localparam logic [1:0] OP_FILL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SWAP_WAIT = 2'd1,
    S_FILL      = 2'd2,
    S_PAL       = 2'd3
  } state_t;

  state_t         r_state;
  logic [7:0]     r_x_start;
  logic [7:0]     r_x_last;
  logic [6:0]     r_y_last;
  logic [7:0]     r_col;
  logic [6:0]     r_row;
  logic           r_empty;
  logic [AW-1:0]  r_row_step;

  logic           w_accept;
  logic [7:0]     w_w;
  logic [6:0]     w_h;
  logic [8:0]     w_x_sum;
  logic [7:0]     w_y_sum;
  logic [7:0]     w_x_end;
  logic [6:0]     w_y_end;
  logic           w_empty;
  logic [AW-1:0]  w_start_addr;
  logic [AW-1:0]  w_row_step;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = ~cmd_ready;
  assign w_accept  = cmd_valid && cmd_ready;

  // Clip the requested rectangle against the framebuffer at accept time
  assign w_w          = (cmd_op == OP_PLOT) ? 8'd1 : cmd_w;
  assign w_h          = (cmd_op == OP_PLOT) ? 7'd1 : cmd_h;
  assign w_x_sum      = 9'(cmd_x) + 9'(w_w);
  assign w_y_sum      = 8'(cmd_y) + 8'(w_h);
  assign w_x_end      = (w_x_sum > 9'(FB_WIDTH))  ? 8'(FB_WIDTH)  : w_x_sum[7:0];
  assign w_y_end      = (w_y_sum > 8'(FB_HEIGHT)) ? 7'(FB_HEIGHT) : w_y_sum[6:0];
  assign w_empty      = (cmd_x >= 8'(FB_WIDTH)) || (cmd_y >= 7'(FB_HEIGHT)) ||
                        (w_w == 8'd0) || (w_h == 7'd0);
  assign w_start_addr = AW'(cmd_y) * AW'(FB_WIDTH) + AW'(cmd_x);
  assign w_row_step   = AW'(FB_WIDTH) - AW'(w_x_end - cmd_x) + AW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_x_start     <= '0;
      r_x_last      <= '0;
      r_y_last      <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_empty       <= 1'b0;
      r_row_step    <= '0;
      fb_write      <= 1'b0;
      fb_address    <= '0;
      fb_data       <= '0;
      pl_write      <= 1'b0;
      pl_address    <= '0;
      pl_data       <= '0;
      current_frame <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (cmd_op == OP_SWAP) begin
              r_state <= S_SWAP_WAIT;
            end else if (cmd_op == OP_PLOT || cmd_op == OP_FILL) begin
              r_state    <= S_FILL;
              r_empty    <= w_empty;
              r_x_start  <= cmd_x;
              r_x_last   <= w_x_end - 8'd1;
              r_y_last   <= w_y_end - 7'd1;
              r_col      <= cmd_x;
              r_row      <= cmd_y;
              r_row_step <= w_row_step;
              fb_write   <= ~w_empty;
              if (!w_empty) begin
                fb_address <= w_start_addr;
                fb_data    <= cmd_index;
              end
            end else begin
              r_state    <= S_PAL;
              pl_write   <= 1'b1;
              pl_address <= cmd_index;
              pl_data    <= cmd_rgb;
            end
          end
        end
        S_SWAP_WAIT: begin
          if (frame_sys) begin
            current_frame <= ~current_frame;
            r_state       <= S_IDLE;
          end
        end
        S_FILL: begin
          // Address tracks row*FB_WIDTH+col incrementally; wrap jumps to next row start
          if (r_empty || (r_col == r_x_last && r_row == r_y_last)) begin
            fb_write <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_col == r_x_last) begin
            r_col      <= r_x_start;
            r_row      <= r_row + 7'd1;
            fb_address <= fb_address + r_row_step;
          end else begin
            r_col      <= r_col + 8'd1;
            fb_address <= fb_address + AW'(1);
          end
        end
        S_PAL: begin
          pl_write <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_command_sequencer.sv
// Directed bench: stimulus pushes expected writes into a scoreboard queue,
// a negedge monitor pops and compares each write strobe the sequencer emits.
module tb_vga_command_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [7:0]  cmd_index;
  logic [23:0] cmd_rgb;
  logic        frame_sys;
  logic        fb_write;
  logic [14:0] fb_address;
  logic [7:0]  fb_data;
  logic        pl_write;
  logic [7:0]  pl_address;
  logic [23:0] pl_data;
  logic        current_frame;
  logic        busy;

  typedef struct {
    bit is_pl;
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  vga_command_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_index(cmd_index), .cmd_rgb(cmd_rgb), .frame_sys(frame_sys),
    .fb_write(fb_write), .fb_address(fb_address), .fb_data(fb_data),
    .pl_write(pl_write), .pl_address(pl_address), .pl_data(pl_data),
    .current_frame(current_frame), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!reset) begin
      if (fb_write && pl_write) begin
        n_cmp++; n_err++;
        $display("FAIL dual_strobe: fb_write and pl_write both high at %0t", $time);
      end
      if (fb_write || pl_write) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: fb=%0b pl=%0b fb_addr=%0d pl_addr=%0d at %0t",
                   fb_write, pl_write, fb_address, pl_address, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_pl) begin
            if (!pl_write || int'(pl_address) != e.addr || int'(pl_data) != e.data) begin
              n_err++;
              $display("FAIL pl_write: got pl=%0b addr=%0h data=%0h, expected addr=%0h data=%0h",
                       pl_write, pl_address, pl_data, e.addr, e.data);
            end
          end else begin
            if (!fb_write || int'(fb_address) != e.addr || int'(fb_data) != e.data) begin
              n_err++;
              $display("FAIL fb_write: got fb=%0b addr=%0d data=%0h, expected addr=%0d data=%0h",
                       fb_write, fb_address, fb_data, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_fb(input int addr, input int data);
    exp_t e;
    e.is_pl = 1'b0; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Present a command and return 1 ns after the accepting edge
  task automatic send(input logic [1:0] op, input int x, input int y, input int w,
                      input int h, input int idx, input int rgb, input bit with_frame);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: cmd_ready still 0 after %0d cycles", guard);
    end
    cmd_op = op; cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h);
    cmd_index = 8'(idx); cmd_rgb = 24'(rgb);
    cmd_valid = 1'b1;
    frame_sys = with_frame;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    frame_sys = 1'b0;
    cmd_x = 8'hFF; cmd_index = 8'hEE;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; frame_sys = 1'b0;
    cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_index = '0; cmd_rgb = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fb_write", fb_write, 0);
    check("rst_pl_write", pl_write, 0);
    check("rst_frame", current_frame, 0);
    check("rst_fb_addr", fb_address, 0);
    check("rst_pl_data", pl_data, 0);

    // PLOT (3,2): one write at 2*160+3
    push_fb(323, 'h2A);
    send(2'd1, 3, 2, 0, 0, 'h2A, 0, 0);
    @(negedge clk);
    check("plot_write", fb_write, 1);
    check("plot_busy", busy, 1);
    @(negedge clk);
    check("plot_ready_after", cmd_ready, 1);
    check("plot_write_off", fb_write, 0);

    // Interior fill back-to-back: 3x2 at (10,5)
    push_fb(810, 9); push_fb(811, 9); push_fb(812, 9);
    push_fb(970, 9); push_fb(971, 9); push_fb(972, 9);
    send(2'd2, 10, 5, 3, 2, 9, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("fill3x2_write", fb_write, 1);
    end
    @(negedge clk);
    check("fill3x2_done", cmd_ready, 1);

    // Corner fill clipped to 2x2
    push_fb(19038, 7); push_fb(19039, 7); push_fb(19198, 7); push_fb(19199, 7);
    send(2'd2, 158, 118, 5, 4, 7, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("clip_write", fb_write, 1);
      check("clip_busy", busy, 1);
    end
    @(negedge clk);
    check("clip_done", cmd_ready, 1);

    // Degenerate fills: zero width, then off-screen x
    send(2'd2, 5, 5, 0, 10, 3, 0, 0);
    @(negedge clk);
    check("w0_busy", busy, 1);
    check("w0_nowrite", fb_write, 0);
    @(negedge clk);
    check("w0_ready", cmd_ready, 1);
    send(2'd2, 200, 5, 4, 4, 3, 0, 0);
    @(negedge clk);
    check("x200_busy", busy, 1);
    check("x200_nowrite", fb_write, 0);
    @(negedge clk);
    check("x200_ready", cmd_ready, 1);

    // SWAP with frame pulse in accept cycle: that pulse is ignored
    send(2'd0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("swap_ignore_frame", current_frame, 0);
    check("swap_busy", busy, 1);
    repeat (48) @(negedge clk);
    check("swap_wait_frame", current_frame, 0);
    check("swap_wait_busy", busy, 1);
    frame_sys = 1'b1;
    @(posedge clk);
    #1 frame_sys = 1'b0;
    @(negedge clk);
    check("swap_toggled", current_frame, 1);
    check("swap_ready", cmd_ready, 1);

    // PALETTE write
    begin
      exp_t e;
      e.is_pl = 1'b1; e.addr = 'h10; e.data = 'h00FF80;
      sb.push_back(e);
    end
    send(2'd3, 0, 0, 0, 0, 'h10, 'h00FF80, 0);
    @(negedge clk);
    check("pal_write", pl_write, 1);
    check("pal_no_fb", fb_write, 0);
    @(negedge clk);
    check("pal_write_off", pl_write, 0);
    check("pal_ready", cmd_ready, 1);
    check("sb_drained", sb.size(), 0);

    // Full-screen fill aborted by reset after 500 writes
    for (int i = 0; i < 600; i++) push_fb(i, 'h55);
    send(2'd2, 0, 0, 160, 120, 'h55, 0, 0);
    repeat (500) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_fb_write", fb_write, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_frame", current_frame, 0);
    check("abort_writes_seen", sb.size(), 100);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_abort_idle", fb_write, 0);
    check("post_abort_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
